// File: rtl/mask_vect_sched.sv
// mask_vect_sched: shares the mask vector engine between a search requester
// and a rule-update requester. An accepted update waits for in-flight searches
// to drain, then writes the NSEG mask lanes one lane per cycle. While an update
// is pending, at most MAX_RUN further searches are granted ahead of it.
// Optional feature macro: MASK_VECT_SCHED_STATS_EN adds search/update/stall
// counters on o_Search_Count, o_Upd_Count and o_Stall_Count.
module mask_vect_sched #(
    parameter int KWID    = 104,
    parameter int NSEG    = KWID / 8,
    parameter int SEGWID  = 10,
    parameter int MASKWID = KWID / 8,
    parameter int VTWID   = SEGWID * NSEG,
    parameter int IDWID   = 8,
    parameter int RD_LAT  = 2,
    parameter int MAX_RUN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_Search_Valid,
    output logic                    o_Search_Ready,
    input  logic [VTWID-1:0]        i_Search_Segment_Vector,
    input  logic [IDWID-1:0]        i_Search_Tag,
    input  logic                    i_Upd_Valid,
    output logic                    o_Upd_Ready,
    input  logic [VTWID-1:0]        i_Upd_Segment_Vector,
    input  logic [MASKWID*NSEG-1:0] i_Upd_Mask_Data,
    output logic [VTWID-1:0]        o_Segment_Vector,
    output logic [MASKWID*NSEG-1:0] o_Mask_Data,
    output logic [NSEG-1:0]         o_Mask_Wr_En,
    output logic                    o_Search_Issue,
    output logic                    o_Result_Valid,
    output logic [IDWID-1:0]        o_Result_Tag,
    output logic                    o_Upd_Done,
`ifdef MASK_VECT_SCHED_STATS_EN
    output logic [31:0]             o_Search_Count,
    output logic [31:0]             o_Upd_Count,
    output logic [31:0]             o_Stall_Count,
`endif
    output logic                    o_Busy
);

    localparam int LW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int RW = $clog2(MAX_RUN + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, WRITE, DONE} state_t;

    state_t                         state, state_nxt;
    logic                           pending;
    logic [RW-1:0]                  run_cnt;
    logic [LW-1:0]                  lane;
    logic [VTWID-1:0]               upd_vec_q;
    logic [MASKWID*NSEG-1:0]        upd_mask_q;
    logic [VTWID-1:0]               srch_vec_q;
    logic [RD_LAT:0]                vld_pipe;
    logic [RD_LAT:0][IDWID-1:0]     tag_pipe;

    logic srch_acc, upd_acc, run_full, pipe_busy, last_lane;

    assign run_full  = pending && (run_cnt == RW'(MAX_RUN));
    assign srch_acc  = i_Search_Valid && o_Search_Ready;
    assign upd_acc   = i_Upd_Valid && o_Upd_Ready;
    assign pipe_busy = |vld_pipe;
    assign last_lane = (lane == LW'(NSEG - 1));

    assign o_Upd_Ready    = !pending;
    assign o_Busy         = (state != IDLE) || pending;
    assign o_Search_Issue = vld_pipe[0];
    assign o_Result_Valid = vld_pipe[RD_LAT];
    assign o_Result_Tag   = tag_pipe[RD_LAT];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state: update waits for run limit or a search gap, then drains
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending && (run_full || !i_Search_Valid)) state_nxt = DRAIN;
            DRAIN:   if (!pipe_busy) state_nxt = WRITE;
            WRITE:   if (last_lane) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: engine port mux and one-hot lane write enable
    always_comb begin
        o_Search_Ready   = 1'b0;
        o_Mask_Wr_En     = '0;
        o_Mask_Data      = '0;
        o_Segment_Vector = srch_vec_q;
        o_Upd_Done       = 1'b0;
        case (state)
            IDLE:  o_Search_Ready = !run_full;
            WRITE: begin
                o_Mask_Wr_En     = {{(NSEG-1){1'b0}}, 1'b1} << lane;
                o_Mask_Data      = upd_mask_q;
                o_Segment_Vector = upd_vec_q;
            end
            DONE:  o_Upd_Done = 1'b1;
            default: ;
        endcase
    end

    // update buffer, run-limit counter, lane index and search vector register
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 1'b0;
            run_cnt    <= '0;
            lane       <= '0;
            upd_vec_q  <= '0;
            upd_mask_q <= '0;
            srch_vec_q <= '0;
        end else begin
            if (upd_acc) begin
                pending    <= 1'b1;
                upd_vec_q  <= i_Upd_Segment_Vector;
                upd_mask_q <= i_Upd_Mask_Data;
            end else if (state == DONE) begin
                pending <= 1'b0;
            end
            if (state == DONE)
                run_cnt <= '0;
            else if (srch_acc && pending && !run_full)
                run_cnt <= run_cnt + RW'(1);
            lane <= (state == WRITE) ? lane + LW'(1) : '0;
            if (srch_acc) srch_vec_q <= i_Search_Segment_Vector;
        end
    end

    // tag shift pipe: stage 0 is the issue cycle, stage RD_LAT the result cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-1:0], srch_acc};
            tag_pipe <= {tag_pipe[RD_LAT-1:0], i_Search_Tag};
        end
    end

`ifdef MASK_VECT_SCHED_STATS_EN
    // wrapping event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            o_Search_Count <= '0;
            o_Upd_Count    <= '0;
            o_Stall_Count  <= '0;
        end else begin
            if (srch_acc) o_Search_Count <= o_Search_Count + 32'd1;
            if (o_Upd_Done) o_Upd_Count <= o_Upd_Count + 32'd1;
            if (i_Search_Valid && !o_Search_Ready) o_Stall_Count <= o_Stall_Count + 32'd1;
        end
    end
`endif

endmodule
